// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: buffered UART transmitter.
//
// Words enter through a valid/ready port into a FIFO_DEPTH-entry FIFO and are
// serialised LSB-first as start / data / [parity] / stop. Frames are sent
// back-to-back with no idle cycle when the FIFO holds more work.
//
// Build option: define UART_TX_PARITY_EN to add one parity bit after the data
// bits (even when parity_odd = 0, odd when parity_odd = 1).
//
// Ports:
//   clk, rst_n   system clock (rising edge), asynchronous active-low reset
//   baud_div     clocks per bit, values below 2 act as 2; sampled per frame
//   parity_odd   parity sense, sampled per frame (unused without parity)
//   s_valid      write request; accepted when s_ready is also high
//   s_data       character to send
//   s_ready      FIFO not full (registered)
//   tx           serial line, idle high
//   tx_busy      high while a frame is on the line
//   frame_done   one-cycle pulse on the final cycle of each frame
//   fifo_level   number of entries held in the FIFO
module uart_tx_cfg #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DIV_W-1:0]                  baud_div,
  input  logic                              parity_odd,
  input  logic                              s_valid,
  input  logic [DATA_W-1:0]                 s_data,
  output logic                              s_ready,
  output logic                              tx,
  output logic                              tx_busy,
  output logic                              frame_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IdxW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  // FIFO
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]   count_q, count_d;
  logic              s_ready_q, s_ready_d;
  logic              push, pop;

  // Serialiser
  state_e            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load;

`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`else
  logic              unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  logic              bit_last;
  logic              fifo_empty;
  logic [DIV_W-1:0]  div_clamped;
  logic [DATA_W-1:0] head;

  assign push        = s_valid & s_ready_q;
  assign bit_last    = (cnt_q == div_q - DIV_W'(1));
  assign fifo_empty  = (count_q == '0);
  assign div_clamped = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
  assign head        = mem[rd_ptr_q];

  // FIFO bookkeeping; s_ready is registered from the next fill level, so a
  // full FIFO refuses a push even in a cycle that also pops.
  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d   = count_q + LvlW'(push) - LvlW'(pop);
    s_ready_d = (count_d != LvlW'(FIFO_DEPTH));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    div_d   = div_q;
    tx_d    = tx_q;
    load    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) load = 1'b1;
      end
      StStart: begin
        if (bit_last) begin
          state_d = StData;
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      StData: begin
        if (bit_last) begin
          cnt_d = '0;
          if (idx_q == IdxW'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
            tx_d    = par_q;
`else
            state_d = StStop;
            tx_d    = 1'b1;
            idx_d   = '0;
`endif
          end else begin
            idx_d   = idx_q + IdxW'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_last) begin
          state_d = StStop;
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
`endif
      StStop: begin
        if (bit_last) begin
          cnt_d = '0;
          if (idx_q == IdxW'(STOP_BITS - 1)) begin
            // Chain straight into the next start bit when work is waiting.
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_d = StIdle;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase

    // Pop the head and freeze the per-frame settings.
    if (load) begin
      state_d = StStart;
      cnt_d   = '0;
      idx_d   = '0;
      shift_d = head;
      div_d   = div_clamped;
      tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = (^head) ^ parity_odd;
`endif
    end
    pop = load;

    busy_d = (state_d != StIdle);
    // Registered pulse that lands on the last cycle of the final stop bit.
    done_d = (state_d == StStop) && (idx_d == IdxW'(STOP_BITS - 1)) &&
             (cnt_d == div_q - DIV_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      s_ready_q <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      div_q     <= DIV_W'(2);
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      s_ready_q <= s_ready_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      div_q     <= div_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  // Storage needs no reset: the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= s_data;
  end

  assign s_ready    = s_ready_q;
  assign tx         = tx_q;
  assign tx_busy    = busy_q;
  assign frame_done = done_q;
  assign fifo_level = count_q;

endmodule
